// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-channel cache-line arbiter, round-robin or fixed priority, one transaction in flight
module mem_arbiter_rr #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int RR_MODE    = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              up_read,
    input  logic [NUM_CH-1:0]              up_write,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   up_address,
    input  logic [NUM_CH*LINE_WIDTH-1:0]   up_wdata,
    output logic [NUM_CH-1:0]              up_resp,
    output logic [LINE_WIDTH-1:0]          up_rdata,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [ADDR_WIDTH-1:0]          mem_address,
    output logic [LINE_WIDTH-1:0]          mem_wdata,
    input  logic                           mem_resp,
    input  logic [LINE_WIDTH-1:0]          mem_rdata,
    output logic [$clog2(NUM_CH)-1:0]      grant_idx,
    output logic                           busy
);

    localparam int IDX_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [NUM_CH-1:0]      req;
    logic [IDX_W-1:0]       last;
    logic [IDX_W-1:0]       win;
    logic                   found;
    logic [IDX_W-1:0]       cand;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LINE_WIDTH-1:0]  wdata_q;
    logic [LINE_WIDTH-1:0]  rdata_q;
    logic                   op_write_q;

    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_CH];
    logic [LINE_WIDTH-1:0]  wdata_arr [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign addr_arr[g]  = up_address[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = up_wdata[g*LINE_WIDTH +: LINE_WIDTH];
    end

    assign req = up_read | up_write;

    // Round-robin scans upward from the channel after the last grant, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        if (RR_MODE != 0) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                cand = IDX_W'((int'(last) + k) % NUM_CH);
                if (!found && req[cand]) begin
                    win   = cand;
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    win = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req != '0) state_next = BUSY;
            BUSY:    if (mem_resp)  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= IDX_W'(NUM_CH - 1);
            grant_idx  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state <= state_next;
            // Write wins when a requester raises both read and write.
            if (state == IDLE && req != '0) begin
                addr_q     <= addr_arr[win];
                wdata_q    <= wdata_arr[win];
                op_write_q <= up_write[win];
                grant_idx  <= win;
                last       <= win;
            end
            if (state == BUSY && mem_resp) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        up_resp = '0;
        if (state == RESP) begin
            up_resp[grant_idx] = 1'b1;
        end
    end

    assign mem_read    = (state == BUSY) && !op_write_q;
    assign mem_write   = (state == BUSY) && op_write_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign up_rdata    = rdata_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - randomized self-checking bench for mem_arbiter_rr against a transaction-level model
module tb_mem_arbiter_rr;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    rd = '0;
    logic [N-1:0]    wr = '0;
    logic [15:0]     addr [N];
    logic [127:0]    wd   [N];
    logic [N*16-1:0]  up_address;
    logic [N*128-1:0] up_wdata;
    logic            mem_resp = 1'b0;
    logic [127:0]    mem_rdata = '0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            up_address[i*16 +: 16]  = addr[i];
            up_wdata[i*128 +: 128]  = wd[i];
        end
    end

    logic [N-1:0]  resp_rr, resp_fp;
    logic [127:0]  rdata_rr, rdata_fp, mwd_rr, mwd_fp;
    logic          mrd_rr, mrd_fp, mwr_rr, mwr_fp, busy_rr, busy_fp;
    logic [15:0]   maddr_rr, maddr_fp;
    logic [1:0]    gidx_rr, gidx_fp;

    mem_arbiter_rr #(.NUM_CH(N), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .up_read(rd), .up_write(wr),
        .up_address(up_address), .up_wdata(up_wdata), .up_resp(resp_rr), .up_rdata(rdata_rr),
        .mem_read(mrd_rr), .mem_write(mwr_rr), .mem_address(maddr_rr), .mem_wdata(mwd_rr),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .grant_idx(gidx_rr), .busy(busy_rr)
    );

    mem_arbiter_rr #(.NUM_CH(N), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .up_read(rd), .up_write(wr),
        .up_address(up_address), .up_wdata(up_wdata), .up_resp(resp_fp), .up_rdata(rdata_fp),
        .mem_read(mrd_fp), .mem_write(mwr_fp), .mem_address(maddr_fp), .mem_wdata(mwd_fp),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .grant_idx(gidx_fp), .busy(busy_fp)
    );

    // Both instances see identical inputs and advance in lockstep; sel_fp chooses which one is observed.
    bit sel_fp = 1'b0;
    wire [N-1:0]  o_resp  = sel_fp ? resp_fp  : resp_rr;
    wire [127:0]  o_rdata = sel_fp ? rdata_fp : rdata_rr;
    wire          o_mrd   = sel_fp ? mrd_fp   : mrd_rr;
    wire          o_mwr   = sel_fp ? mwr_fp   : mwr_rr;
    wire [15:0]   o_maddr = sel_fp ? maddr_fp : maddr_rr;
    wire [127:0]  o_mwd   = sel_fp ? mwd_fp   : mwd_rr;
    wire [1:0]    o_gidx  = sel_fp ? gidx_fp  : gidx_rr;
    wire          o_busy  = sel_fp ? busy_fp  : busy_rr;

    int checks = 0;
    int errors = 0;
    int m_last = N - 1;
    logic [127:0] last_data = '0;

    function automatic int pick(input logic [N-1:0] r, input int last, input bit rr);
        if (rr) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (last + k) % N;
                if (r[2'(idx)]) return idx;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (r[2'(i)]) return i;
            end
        end
        return -1;
    endfunction

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        rd = '0;
        wr = '0;
        mem_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_last = N - 1;
    endtask

    task automatic do_txn(input int lat, input bit drop, input bit release_req, input bit scramble,
                          output int w, output int waited);
        logic [N-1:0] s_req, s_wr;
        logic [15:0]  sa  [N];
        logic [127:0] swd [N];
        logic [127:0] data;
        bit e_wr;
        int cnt;
        cnt = 0;
        w = -1;
        do begin
            s_req = rd | wr;
            s_wr  = wr;
            sa    = addr;
            swd   = wd;
            @(negedge clk);
            cnt++;
        end while (!(o_mrd || o_mwr) && cnt < 20);
        waited = cnt;
        checks++;
        if (!(o_mrd || o_mwr)) begin
            errors++;
            $display("FAIL grant_timeout got no mem request after %0d cycles, required one", cnt);
            return;
        end
        w = pick(s_req, m_last, !sel_fp);
        if (w < 0) w = 0;
        e_wr = s_wr[2'(w)];
        if (!sel_fp) m_last = w;
        checks++;
        if (o_gidx !== 2'(w)) begin
            errors++; $display("FAIL grant_idx got %0d required %0d", o_gidx, w);
        end
        checks++;
        if (o_maddr !== sa[w]) begin
            errors++; $display("FAIL mem_address got %h required %h", o_maddr, sa[w]);
        end
        checks++;
        if (o_mwr !== e_wr || o_mrd !== !e_wr) begin
            errors++; $display("FAIL mem_op got rd=%b wr=%b required wr=%b", o_mrd, o_mwr, e_wr);
        end
        if (e_wr) begin
            checks++;
            if (o_mwd !== swd[w]) begin
                errors++; $display("FAIL mem_wdata got %h required %h", o_mwd, swd[w]);
            end
        end
        checks++;
        if (o_busy !== 1'b1 || o_resp !== '0) begin
            errors++; $display("FAIL busy_phase got busy=%b resp=%b required busy=1 resp=0", o_busy, o_resp);
        end
        if (drop) begin
            rd[w] = 1'b0;
            wr[w] = 1'b0;
        end
        for (int i = 1; i < lat; i++) begin
            if (scramble) begin
                for (int c = 0; c < N; c++) begin
                    addr[c] = 16'($urandom);
                    wd[c]   = rnd_line();
                end
            end
            @(negedge clk);
            checks++;
            if (o_maddr !== sa[w] || o_mwr !== e_wr || o_mrd !== !e_wr) begin
                errors++;
                $display("FAIL busy_hold got addr=%h rd=%b wr=%b required addr=%h wr=%b",
                         o_maddr, o_mrd, o_mwr, sa[w], e_wr);
            end
        end
        data = rnd_line();
        mem_rdata = data;
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        mem_rdata = rnd_line();
        last_data = data;
        checks++;
        if (o_resp !== 4'(1 << w)) begin
            errors++; $display("FAIL up_resp got %b required %b", o_resp, 4'(1 << w));
        end
        checks++;
        if (o_rdata !== data) begin
            errors++; $display("FAIL up_rdata got %h required %h", o_rdata, data);
        end
        checks++;
        if (o_mrd !== 1'b0 || o_mwr !== 1'b0 || o_busy !== 1'b1) begin
            errors++; $display("FAIL resp_phase got rd=%b wr=%b busy=%b required 0 0 1", o_mrd, o_mwr, o_busy);
        end
        if (release_req) begin
            rd[w] = 1'b0;
            wr[w] = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (o_resp !== '0 || o_busy !== 1'b0 || o_mrd !== 1'b0 || o_mwr !== 1'b0 ||
            o_rdata !== data || o_gidx !== 2'(w)) begin
            errors++;
            $display("FAIL idle_after got resp=%b busy=%b rd=%b wr=%b gidx=%0d rdata=%h required 0 0 0 0 %0d %h",
                     o_resp, o_busy, o_mrd, o_mwr, o_gidx, o_rdata, w, data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_resp !== '0 || o_rdata !== '0 || o_mrd !== 1'b0 || o_mwr !== 1'b0 ||
            o_maddr !== '0 || o_mwd !== '0 || o_gidx !== '0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got resp=%b rd=%b wr=%b addr=%h gidx=%0d busy=%b required all zero",
                     o_resp, o_mrd, o_mwr, o_maddr, o_gidx, o_busy);
        end
        apply_reset();
    endtask

    task automatic test_single_read();
        int w, waited;
        addr[0] = 16'h1230;
        rd = 4'b0001;
        do_txn(4, 1'b0, 1'b1, 1'b0, w, waited);
        checks++;
        if (waited !== 1) begin
            errors++; $display("FAIL read_latency got %0d required 1", waited);
        end
        checks++;
        if (w !== 0) begin
            errors++; $display("FAIL single_grant got %0d required 0", w);
        end
    endtask

    task automatic test_alternate();
        int w, waited;
        int order [4] = '{0, 1, 0, 1};
        apply_reset();
        addr[0] = 16'h0100;
        addr[1] = 16'h0040;
        wd[1]   = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
        rd = 4'b0001;
        wr = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            do_txn(1, 1'b0, 1'b0, 1'b0, w, waited);
            checks++;
            if (w !== order[i]) begin
                errors++; $display("FAIL alternate_order[%0d] got %0d required %0d", i, w, order[i]);
            end
        end
        rd = '0;
        wr = '0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int w, waited;
        rd = 4'b1000;
        do_txn(2, 1'b0, 1'b1, 1'b0, w, waited);
        rd = 4'b0101;
        do_txn(1, 1'b0, 1'b1, 1'b0, w, waited);
        checks++;
        if (w !== 0) begin
            errors++; $display("FAIL wrap_first got %0d required 0", w);
        end
        do_txn(1, 1'b0, 1'b1, 1'b0, w, waited);
        checks++;
        if (w !== 2) begin
            errors++; $display("FAIL wrap_second got %0d required 2", w);
        end
    endtask

    task automatic test_fixed_priority();
        int w, waited;
        sel_fp = 1'b1;
        apply_reset();
        rd = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            do_txn(1, 1'b0, 1'b0, 1'b0, w, waited);
            checks++;
            if (w !== 0) begin
                errors++; $display("FAIL fixed_prio[%0d] got %0d required 0", i, w);
            end
        end
        rd[0] = 1'b0;
        @(negedge clk);
        do_txn(1, 1'b0, 1'b1, 1'b0, w, waited);
        checks++;
        if (w !== 1) begin
            errors++; $display("FAIL fixed_next got %0d required 1", w);
        end
        rd = '0;
        sel_fp = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_busy();
        int w, waited;
        apply_reset();
        rd = 4'b0010;
        @(negedge clk);
        checks++;
        if (o_gidx !== 2'd1 || o_mrd !== 1'b1) begin
            errors++; $display("FAIL rb_grant got gidx=%0d rd=%b required 1 1", o_gidx, o_mrd);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_resp !== '0 || o_mrd !== 1'b0 || o_mwr !== 1'b0 || o_busy !== 1'b0 ||
            o_maddr !== '0 || o_gidx !== '0 || o_rdata !== '0) begin
            errors++;
            $display("FAIL rb_async got resp=%b rd=%b busy=%b addr=%h gidx=%0d required all zero",
                     o_resp, o_mrd, o_busy, o_maddr, o_gidx);
        end
        mem_resp = 1'b1;
        mem_rdata = rnd_line();
        @(negedge clk);
        mem_resp = 1'b0;
        rst_n = 1'b1;
        m_last = N - 1;
        rd = 4'b0011;
        checks++;
        if (o_resp !== '0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL rb_no_resp got resp=%b busy=%b required 0 0", o_resp, o_busy);
        end
        do_txn(1, 1'b0, 1'b1, 1'b0, w, waited);
        checks++;
        if (w !== 0) begin
            errors++; $display("FAIL rb_first_after got %0d required 0", w);
        end
        do_txn(1, 1'b0, 1'b1, 1'b0, w, waited);
    endtask

    task automatic test_drop();
        int w, waited;
        logic [127:0] held;
        rd = 4'b0001;
        addr[0] = 16'hbeef;
        do_txn(3, 1'b1, 1'b1, 1'b0, w, waited);
        held = last_data;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                mem_resp = 1'b1;
                mem_rdata = rnd_line();
            end else begin
                mem_resp = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (o_busy !== 1'b0 || o_mrd !== 1'b0 || o_resp !== '0 || o_rdata !== held) begin
                errors++;
                $display("FAIL drop_idle[%0d] got busy=%b rd=%b resp=%b rdata=%h required 0 0 0 %h",
                         i, o_busy, o_mrd, o_resp, o_rdata, held);
            end
        end
        mem_resp = 1'b0;
    endtask

    task automatic test_random(input bit fp, input int count);
        int w, waited;
        sel_fp = fp;
        apply_reset();
        for (int t = 0; t < count; t++) begin
            for (int c = 0; c < N; c++) begin
                if (!(rd[c] || wr[c]) && $urandom_range(0, 2) == 0) begin
                    int op;
                    op = $urandom_range(1, 3);
                    rd[c] = (op != 2);
                    wr[c] = (op != 1);
                    addr[c] = 16'($urandom);
                    wd[c] = rnd_line();
                end
            end
            if ((rd | wr) == '0) begin
                rd[$urandom_range(0, N - 1)] = 1'b1;
            end
            do_txn($urandom_range(1, 4), $urandom_range(0, 7) == 0, 1'b1, 1'b1, w, waited);
        end
        rd = '0;
        wr = '0;
        sel_fp = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            addr[i] = 16'(i * 16'h0100);
            wd[i]   = {4{32'(i)}};
        end
        test_reset();
        test_single_read();
        test_alternate();
        test_wrap();
        test_fixed_priority();
        test_reset_busy();
        test_drop();
        test_random(1'b0, 40);
        test_random(1'b1, 20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion within time limit required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- N-channel arbiter between upstream cache-side requesters (L1 I/D victim buffers, prefetchers) and a single downstream cache-line port (L2).
- Parametrised successor of the fixed two-port I/D arbiter. Adds:
  - configurable channel count;
  - fixed-priority or round-robin selection;
  - registered downstream request;
  - registered, per-channel response.
- One transaction is in flight at a time. Request signals are latched at grant so downstream inputs stay stable.

Parameters:
NUM_CH, 2, number of upstream channels (>=2)
ADDR_WIDTH, 16, address width (lc3b_word)
LINE_WIDTH, 128, cache-line data width (lc3b_cacheline)
RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
up_read  in  NUM_CH  per-channel read request, held until up_resp
up_write  in  NUM_CH  per-channel write request, held until up_resp
up_address  in  NUM_CH*ADDR_WIDTH  packed addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
up_wdata  in  NUM_CH*LINE_WIDTH  packed write lines, channel i at [i*LINE_WIDTH +: LINE_WIDTH]
up_resp  out  NUM_CH  one-cycle completion pulse, one-hot
up_rdata  out  LINE_WIDTH  read line, broadcast, valid when any up_resp bit is set
mem_read  out  1  downstream read
mem_write  out  1  downstream write
mem_address  out  ADDR_WIDTH  downstream address
mem_wdata  out  LINE_WIDTH  downstream write line
mem_resp  in  1  downstream completion
mem_rdata  in  LINE_WIDTH  downstream read line, valid with mem_resp
grant_idx  out  $clog2(NUM_CH)  index of current/last granted channel (debug)
busy  out  1  high in BUSY and RESP

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all outputs 0.
  - Round-robin pointer last=NUM_CH-1, so channel 0 wins first after reset.
  - Reset mid-transaction abandons the downstream transaction with no up_resp; the downstream side is reset by the same rst_n.
- Request vector: req[i] = up_read[i] | up_write[i].
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - mem_read=mem_write=0; up_resp=0.
  - If req != 0, select winner w:
    - RR_MODE=1: first set bit searching from (last+1) mod NUM_CH upward, wrapping.
    - RR_MODE=0: lowest set index.
  - At the edge, latch addr/wdata/op of w, grant_idx=w, last=w, go BUSY.
  - Op latch: write if up_write[w], else read. If both are set, write takes precedence (protocol error, not flagged).
- BUSY:
  - mem_address and mem_wdata come from the latch.
  - Exactly one of mem_read/mem_write is high per the latched op.
  - Upstream changes are ignored.
  - On mem_resp: capture mem_rdata into the rdata register, go RESP.
- RESP (exactly one cycle):
  - mem_read=mem_write=0; up_resp[grant_idx]=1; up_rdata = captured line (write: captured value, don't-care).
  - Next state IDLE.
- Requester contract:
  - Sample up_resp at the edge ending RESP and deassert the request before the following IDLE evaluation.
  - A request still high in IDLE is treated as a new request.
- Latency:
  - Request seen in IDLE at cycle t gives mem_read/write high at t+1.
  - mem_resp at cycle k gives up_resp at k+1.
  - Minimum 3 cycles per transaction (IDLE, BUSY, RESP) with a 1-cycle downstream.
- Requests arriving during BUSY/RESP wait; no queueing beyond the held request.
- A requester dropping its request during BUSY: the transaction still completes and up_resp still pulses.
- Round-robin fairness: with all channels requesting continuously, each channel is served once per NUM_CH transactions.
- Fixed priority: higher indices may starve; this is intended.
- mem_resp outside BUSY is ignored.
- up_rdata holds its value until the next capture.
- grant_idx holds its value after RESP.

Test Plan:
- NUM_CH=2, RR: ch0 read addr 16'h1230, mem_resp after 4 cycles with line 128'hA5..A5 -> mem_read high 1 cycle after request for 4 cycles, mem_address=16'h1230; up_resp=2'b01 one cycle after mem_resp; up_rdata=A5..A5.
- NUM_CH=2, RR: ch0 read and ch1 write (addr 16'h0040, wdata 128'h1234...) held continuously, 1-cycle downstream -> grant order 0,1,0,1; during ch1 grants mem_write=1, mem_wdata=128'h1234...; up_resp pulses alternate 01/10.
- NUM_CH=4, RR_MODE=0: all four request repeatedly -> ch0 always served; ch1..3 never granted while ch0 re-requests.
- NUM_CH=4, RR: after grant to ch3, ch0 and ch2 requesting -> ch0 granted next (wrap), then ch2.
- Reset in BUSY: ch1 granted, rst_n low 1 cycle before mem_resp -> all outputs 0 immediately; no up_resp; after release, ch0 request wins first.
- ch0 drops up_read mid-BUSY; mem_resp arrives -> up_resp[0] still pulses once; FSM returns to IDLE; no spurious re-grant.
